// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the RX and TX shift registers:
// one-hot frame states, configuration constants and the parity helper.
package uart_pkg;

    typedef enum logic [4:0] {
        IDLE      = 5'b0_0001,
        STARTBIT  = 5'b0_0010,
        DATABITS  = 5'b0_0100,
        PARITYBIT = 5'b0_1000,
        STOPBIT   = 5'b1_0000
    } uartState_e;

    localparam logic EVEN      = 1'b0;
    localparam logic ODD       = 1'b1;
    localparam logic BIGEND    = 1'b1;
    localparam logic LITTLEEND = 1'b0;
    localparam logic EMPTY     = 1'b0;
    localparam logic FULL      = 1'b1;

    // Parity bit value a correct frame carries for the given data byte.
    function automatic logic expectedParity(input logic [7:0] data, input logic method);
        logic result;
        case (method)
            EVEN:    result = ^data;
            ODD:     result = ~^data;
            default: result = ^data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/uart_rx_shift_register_if.sv
// RX FIFO write port plus the per-frame error pulses reported alongside it.
interface uart_rx_shift_register_if;
    logic       n_FifoWe_o;
    logic [7:0] FifoData_o;
    logic       p_FifoFull_i;
    logic       p_ParityErr_o;
    logic       p_FrameErr_o;
    logic       p_Overrun_o;

    modport master (
        output n_FifoWe_o, FifoData_o, p_ParityErr_o, p_FrameErr_o, p_Overrun_o,
        input  p_FifoFull_i
    );

    modport slave (
        input  n_FifoWe_o, FifoData_o, p_ParityErr_o, p_FrameErr_o, p_Overrun_o,
        output p_FifoFull_i
    );
endinterface

// File: rtl/uart_rx_sync_edge.sv
// Two-flop synchronizer for the rx pad and a falling-edge detect that compares
// the synced line only between consecutive sample ticks.
module uart_rx_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic sampleTick,
    input  logic serialIn,
    output logic rxSync,
    output logic fallEdge
);

    logic sync1_r;
    logic sync2_r;
    logic prevSample_r;

    // Synchronizer chain and previous-tick sample; idle line level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r      <= 1'b1;
            sync2_r      <= 1'b1;
            prevSample_r <= 1'b1;
        end else begin
            sync1_r <= serialIn;
            sync2_r <= sync1_r;
            if (sampleTick) begin
                prevSample_r <= sync2_r;
            end else begin
                prevSample_r <= prevSample_r;
            end
        end
    end

    assign rxSync   = sync2_r;
    assign fallEdge = sampleTick & prevSample_r & ~sync2_r;

endmodule

// File: rtl/uart_rx_shift_register.sv
// UART receive shift register: oversampled start detection, mid-bit sampling,
// byte assembly with optional parity, and a single-cycle active-low FIFO write.
module uart_rx_shift_register
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p_SampleTick_i,
    input  logic       SerialData_i,
    input  logic       p_BigEnd_i,
    input  logic       p_ParityEnable_i,
    input  logic       ParityMethod_i,
    output logic [4:0] State_o,
    uart_rx_shift_register_if.master fifoIf
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

    uartState_e    state_r,    stateNext_s;
    logic [TW-1:0] tickCnt_r,  tickCntNext_s;
    logic [3:0]    bitCnt_r,   bitCntNext_s;
    logic [7:0]    data_r,     dataNext_s;
    logic          parMiss_r,  parMissNext_s;
    logic          weN_r,      weNNext_s;
    logic [7:0]    fifoData_r, fifoDataNext_s;
    logic          parErr_r,   parErrNext_s;
    logic          frameErr_r, frameErrNext_s;
    logic          overrun_r,  overrunNext_s;
    logic          rxSync_s;
    logic          fallEdge_s;
    logic          midSample_s;
    logic [2:0]    bitIdx_s;

    uart_rx_sync_edge u_syncEdge (
        .clk        (clk),
        .rst        (rst),
        .sampleTick (p_SampleTick_i),
        .serialIn   (SerialData_i),
        .rxSync     (rxSync_s),
        .fallEdge   (fallEdge_s)
    );

    assign midSample_s = p_SampleTick_i && (tickCnt_r == MID_TICK);
    assign bitIdx_s    = (p_BigEnd_i == LITTLEEND) ? bitCnt_r[2:0] : (3'd7 - bitCnt_r[2:0]);

    // Next-state, counter, assembly and output-strobe logic for the frame FSM.
    always_comb begin
        stateNext_s    = state_r;
        tickCntNext_s  = tickCnt_r;
        bitCntNext_s   = bitCnt_r;
        dataNext_s     = data_r;
        parMissNext_s  = parMiss_r;
        weNNext_s      = 1'b1;
        fifoDataNext_s = fifoData_r;
        parErrNext_s   = 1'b0;
        frameErrNext_s = 1'b0;
        overrunNext_s  = 1'b0;

        if (p_SampleTick_i && (state_r != IDLE)) begin
            tickCntNext_s = (tickCnt_r == LAST_TICK) ? {TW{1'b0}} : tickCnt_r + TW'(1);
        end else begin
            tickCntNext_s = tickCnt_r;
        end

        case (state_r)
            IDLE: begin
                if (fallEdge_s) begin
                    stateNext_s   = STARTBIT;
                    tickCntNext_s = {TW{1'b0}};
                    bitCntNext_s  = 4'd0;
                    parMissNext_s = 1'b0;
                end else begin
                    stateNext_s = IDLE;
                end
            end
            STARTBIT: begin
                if (midSample_s) begin
                    stateNext_s = rxSync_s ? IDLE : DATABITS;
                end else begin
                    stateNext_s = STARTBIT;
                end
            end
            DATABITS: begin
                if (midSample_s) begin
                    dataNext_s[bitIdx_s] = rxSync_s;
                    bitCntNext_s         = bitCnt_r + 4'd1;
                    if (bitCnt_r == 4'd7) begin
                        stateNext_s = p_ParityEnable_i ? PARITYBIT : STOPBIT;
                    end else begin
                        stateNext_s = DATABITS;
                    end
                end else begin
                    stateNext_s = DATABITS;
                end
            end
            PARITYBIT: begin
                if (midSample_s) begin
                    parMissNext_s = (rxSync_s != expectedParity(data_r, ParityMethod_i));
                    stateNext_s   = STOPBIT;
                end else begin
                    stateNext_s = PARITYBIT;
                end
            end
            STOPBIT: begin
                // Leave at mid stop bit so the next start edge can be caught early.
                if (midSample_s) begin
                    stateNext_s   = IDLE;
                    tickCntNext_s = {TW{1'b0}};
                    if (!rxSync_s) begin
                        frameErrNext_s = 1'b1;
                    end else if (fifoIf.p_FifoFull_i == FULL) begin
                        overrunNext_s = 1'b1;
                    end else begin
                        weNNext_s      = 1'b0;
                        fifoDataNext_s = data_r;
                        parErrNext_s   = parMiss_r;
                    end
                end else begin
                    stateNext_s = STOPBIT;
                end
            end
            default: begin
                stateNext_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            tickCnt_r  <= {TW{1'b0}};
            bitCnt_r   <= 4'd0;
            data_r     <= 8'h00;
            parMiss_r  <= 1'b0;
            weN_r      <= 1'b1;
            fifoData_r <= 8'h00;
            parErr_r   <= 1'b0;
            frameErr_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            state_r    <= stateNext_s;
            tickCnt_r  <= tickCntNext_s;
            bitCnt_r   <= bitCntNext_s;
            data_r     <= dataNext_s;
            parMiss_r  <= parMissNext_s;
            weN_r      <= weNNext_s;
            fifoData_r <= fifoDataNext_s;
            parErr_r   <= parErrNext_s;
            frameErr_r <= frameErrNext_s;
            overrun_r  <= overrunNext_s;
        end
    end

    assign State_o              = state_r;
    assign fifoIf.n_FifoWe_o    = weN_r;
    assign fifoIf.FifoData_o    = fifoData_r;
    assign fifoIf.p_ParityErr_o = parErr_r;
    assign fifoIf.p_FrameErr_o  = frameErr_r;
    assign fifoIf.p_Overrun_o   = overrun_r;

endmodule

// File: tb/tb_uart_rx_shift_register.sv
// Bench for uart_rx_shift_register: directed and random frames driven on the
// serial line, outcomes compared against a byte-level frame model.
module tb_uart_rx_shift_register;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       serial = 1'b1;
    logic       bigEnd = 1'b0;
    logic       parEn = 1'b0;
    logic       parMethod = 1'b0;
    logic [4:0] state;

    int checks = 0;
    int errors = 0;

    logic [7:0] wrData[$];
    bit         wrPar[$];
    int         frameErrCnt = 0;
    int         overrunCnt = 0;
    int         strayParCnt = 0;

    uart_rx_shift_register_if fifoBus ();

    uart_rx_shift_register #(.OVERSAMPLE(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .p_SampleTick_i   (tick),
        .SerialData_i     (serial),
        .p_BigEnd_i       (bigEnd),
        .p_ParityEnable_i (parEn),
        .ParityMethod_i   (parMethod),
        .State_o          (state),
        .fifoIf           (fifoBus)
    );

    always #5 clk = ~clk;

    initial begin : tickGen
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            tick = (ph == 3);
            ph = (ph + 1) % 4;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (fifoBus.n_FifoWe_o == 1'b0) begin
                wrData.push_back(fifoBus.FifoData_o);
                wrPar.push_back(fifoBus.p_ParityErr_o);
            end else if (fifoBus.p_ParityErr_o) begin
                strayParCnt++;
            end
            if (fifoBus.p_FrameErr_o) frameErrCnt++;
            if (fifoBus.p_Overrun_o)  overrunCnt++;
        end
    end

    task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic lineDataBit(input logic [7:0] v, input logic be, input int i);
        return be ? v[7 - i] : v[i];
    endfunction

    // Parity bit a well-formed frame carries: makes the total count of ones even (EVEN) or odd (ODD).
    function automatic logic goodParity(input logic [7:0] v, input logic odd);
        int ones;
        ones = $countones(v);
        return odd ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1);
    endfunction

    task automatic holdLine(input logic v, input int n);
        serial = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic sendFrame(input logic [7:0] v, input logic be, input logic pe, input logic pm,
                             input logic badPar, input logic stopVal);
        bigEnd = be; parEn = pe; parMethod = pm;
        holdLine(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) holdLine(lineDataBit(v, be, i), BIT_CLKS);
        if (pe) holdLine(goodParity(v, pm) ^ badPar, BIT_CLKS);
        holdLine(stopVal, BIT_CLKS);
    endtask

    task automatic runFrame(input string tag, input logic [7:0] v, input logic be, input logic pe,
                            input logic pm, input logic badPar, input logic stopVal, input logic full);
        int w0, f0, o0, s0, expW, expF, expO;
        w0 = wrData.size(); f0 = frameErrCnt; o0 = overrunCnt; s0 = strayParCnt;
        fifoBus.p_FifoFull_i = full;
        sendFrame(v, be, pe, pm, badPar, stopVal);
        holdLine(1'b1, 2 * BIT_CLKS);
        expW = 0; expF = 0; expO = 0;
        if (!stopVal) expF = 1;
        else if (full) expO = 1;
        else expW = 1;
        expectEq({tag, "_writes"}, wrData.size() - w0, expW);
        expectEq({tag, "_frameErr"}, frameErrCnt - f0, expF);
        expectEq({tag, "_overrun"}, overrunCnt - o0, expO);
        expectEq({tag, "_strayPar"}, strayParCnt - s0, 0);
        expectEq({tag, "_idle"}, state, 5'b0_0001);
        if (expW == 1 && wrData.size() == w0 + 1) begin
            expectEq({tag, "_data"}, wrData[w0], v);
            expectEq({tag, "_parErr"}, wrPar[w0], pe && badPar);
            expectEq({tag, "_dataHeld"}, fifoBus.FifoData_o, v);
        end
        fifoBus.p_FifoFull_i = 1'b0;
    endtask

    initial begin : mainSeq
        int w0, f0, o0, s0;
        fifoBus.p_FifoFull_i = 1'b0;
        repeat (4) @(negedge clk);
        expectEq("rst_state", state, 5'b0_0001);
        expectEq("rst_we", fifoBus.n_FifoWe_o, 1'b1);
        expectEq("rst_data", fifoBus.FifoData_o, 8'h00);
        expectEq("rst_flags", {fifoBus.p_ParityErr_o, fifoBus.p_FrameErr_o, fifoBus.p_Overrun_o}, 3'b000);
        rst = 1'b0;
        holdLine(1'b1, 2 * BIT_CLKS);

        runFrame("lsbA5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        runFrame("bigEnd80", 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        runFrame("parEvenOk", 8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        runFrame("parEvenBad", 8'h03, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        runFrame("parOddBad", 8'hC7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Short low pulse on the line: start bit rejected at mid sample.
        w0 = wrData.size(); f0 = frameErrCnt;
        holdLine(1'b0, 16);
        expectEq("glitch_startSeen", state, 5'b0_0010);
        holdLine(1'b1, 2 * BIT_CLKS);
        expectEq("glitch_idle", state, 5'b0_0001);
        expectEq("glitch_events", (wrData.size() - w0) + (frameErrCnt - f0), 0);

        // Framing error, then the line stays low: no new frame may start.
        w0 = wrData.size(); f0 = frameErrCnt;
        sendFrame(8'h5C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        holdLine(1'b0, 3 * BIT_CLKS);
        expectEq("brk_frameErr", frameErrCnt - f0, 1);
        expectEq("brk_writes", wrData.size() - w0, 0);
        expectEq("brk_idle", state, 5'b0_0001);
        holdLine(1'b1, BIT_CLKS);
        runFrame("afterBrk", 8'h69, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        runFrame("overrun5A", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Reset in the middle of data bit 4 aborts the frame silently.
        w0 = wrData.size(); f0 = frameErrCnt; o0 = overrunCnt; s0 = strayParCnt;
        bigEnd = 1'b0; parEn = 1'b0;
        holdLine(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) holdLine(lineDataBit(8'hE7, 1'b0, i), BIT_CLKS);
        holdLine(lineDataBit(8'hE7, 1'b0, 4), 40);
        expectEq("rstMid_busy", state, 5'b0_0100);
        serial = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expectEq("rstMid_idle", state, 5'b0_0001);
        holdLine(1'b1, 3 * BIT_CLKS);
        expectEq("rstMid_events", (wrData.size() - w0) + (frameErrCnt - f0) + (overrunCnt - o0) + (strayParCnt - s0), 0);
        runFrame("afterRst3C", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Two frames separated only by their one stop bit.
        w0 = wrData.size();
        sendFrame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        sendFrame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        holdLine(1'b1, 2 * BIT_CLKS);
        expectEq("b2b_writes", wrData.size() - w0, 2);
        if (wrData.size() == w0 + 2) begin
            expectEq("b2b_first", wrData[w0], 8'h11);
            expectEq("b2b_second", wrData[w0 + 1], 8'h22);
        end

        for (int n = 0; n < 16; n++) begin
            logic [7:0] v;
            logic be, pe, pm, bad, stopv, full;
            v     = 8'($urandom_range(0, 255));
            be    = 1'($urandom_range(0, 1));
            pe    = 1'($urandom_range(0, 1));
            pm    = 1'($urandom_range(0, 1));
            bad   = 1'($urandom_range(0, 1));
            stopv = ($urandom_range(0, 9) != 0);
            full  = ($urandom_range(0, 9) == 0);
            runFrame($sformatf("rnd%0d", n), v, be, pe, pm, bad, stopv, full);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
